// File: rtl/bcd3_to_bin_seq.sv
// rtl/bcd3_to_bin_seq.sv - signed NDIG-digit BCD to two's-complement binary, one digit per clock
module bcd3_to_bin_seq #(
   parameter int NDIG = 3,
   parameter int W    = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*NDIG-1:0]   BCD_IN,
   input  logic                sign_in,
   output logic signed [W-1:0] BIN_OUT,
   output logic                err,
   output logic                busy,
   output logic                done
);

   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, CONV, FIX, DONE} state_t;

   state_t            state_q;
   logic [4*NDIG-1:0] bcd_q;
   logic              sign_q;
   logic              bad_q;
   logic [W-2:0]      acc_q;
   logic [CW-1:0]     cnt_q;
   logic [W-1:0]      bin_q;
   logic              err_q;
   logic              done_q;

   logic              bad_digit;
   logic [3:0]        digit;
   logic [W-2:0]      acc_d;
   logic [W-1:0]      mag_ext;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (BCD_IN[4*i +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end

   // acc*10 as shift-add; W-1 bits always holds 10^NDIG-1
   always_comb begin
      digit   = bcd_q[4*int'(cnt_q) +: 4];
      acc_d   = (acc_q << 3) + (acc_q << 1) + {{(W-5){1'b0}}, digit};
      mag_ext = {1'b0, acc_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         sign_q  <= 1'b0;
         bad_q   <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  bcd_q  <= BCD_IN;
                  sign_q <= sign_in;
                  acc_q  <= '0;
                  cnt_q  <= CW'(NDIG - 1);
                  bad_q  <= bad_digit;
                  // invalid requests route through FIX so done lands one cycle after acceptance
                  if (bad_digit) begin
                     err_q   <= 1'b1;
                     bin_q   <= '0;
                     state_q <= FIX;
                  end else begin
                     state_q <= CONV;
                  end
               end
            end
            CONV: begin
               acc_q <= acc_d;
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FIX: begin
               if (!bad_q) begin
                  bin_q <= sign_q ? (~mag_ext + 1'b1) : mag_ext;
                  err_q <= 1'b0;
               end
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign BIN_OUT = bin_q;
   assign err     = err_q;
   assign done    = done_q;
   assign busy    = (state_q != IDLE);

endmodule
